// File: rtl/v850_pkg.sv
// Shared types for the V850 instruction prefetch path.
package v850_pkg;

    localparam int unsigned HW_W = 16;

    typedef logic [HW_W-1:0] halfword_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/v850_hw_ring.sv
// Circular halfword buffer: partial-beat write at the tail, head-relative window read.
module v850_hw_ring
    import v850_pkg::*;
#(
    parameter int unsigned  DEPTH_HW  = 8,
    parameter int unsigned  BEAT_HW   = 2,
    parameter int unsigned  WINDOW_HW = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH_HW),
    localparam int unsigned CNT_W     = $clog2(DEPTH_HW + 1),
    localparam int unsigned WC_W      = $clog2(WINDOW_HW + 1),
    localparam int unsigned SKIP_W    = (BEAT_HW > 1) ? $clog2(BEAT_HW) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_wr_en,
    input  logic [SKIP_W-1:0]           i_wr_skip,
    input  logic [BEAT_HW*HW_W-1:0]     i_wr_data,
    input  logic [WC_W-1:0]             i_rd_cnt,
    output logic [CNT_W-1:0]            o_count,
    output logic [WINDOW_HW*HW_W-1:0]   o_window,
    output logic [WC_W-1:0]             o_win_count
);

    halfword_t          r_mem [DEPTH_HW];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_wr_num;
    logic [WC_W-1:0]    w_win_count;

    assign w_wr_num = i_wr_en ? (CNT_W'(BEAT_HW) - CNT_W'(i_wr_skip)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(i_rd_cnt);
            r_tail  <= r_tail + PTR_W'(w_wr_num);
            r_count <= r_count + w_wr_num - CNT_W'(i_rd_cnt);
        end
    end

    // Halfwords below the skip offset precede an unaligned target and are dropped.
    always_ff @(posedge clk) begin
        if (i_wr_en && !i_flush) begin
            for (int unsigned i = 0; i < BEAT_HW; i++) begin
                if (i >= 32'(i_wr_skip)) begin
                    r_mem[r_tail + PTR_W'(i) - PTR_W'(i_wr_skip)] <= i_wr_data[i*HW_W +: HW_W];
                end
            end
        end
    end

    assign w_win_count = (r_count > CNT_W'(WINDOW_HW)) ? WC_W'(WINDOW_HW) : WC_W'(r_count);

    always_comb begin
        o_window = '0;
        for (int unsigned i = 0; i < WINDOW_HW; i++) begin
            if (i < 32'(w_win_count)) begin
                o_window[i*HW_W +: HW_W] = r_mem[r_head + PTR_W'(i)];
            end
        end
    end

    assign o_win_count = w_win_count;
    assign o_count     = r_count;

endmodule

// File: rtl/v850_prefetch_queue.sv
// V850 instruction prefetcher: one-outstanding beat fetch FSM, redirect/flush and decoder window.
module v850_prefetch_queue
    import v850_pkg::*;
#(
    parameter int unsigned      FETCH_W   = 32,
    parameter int unsigned      DEPTH_HW  = 8,
    parameter int unsigned      WINDOW_HW = 4,
    parameter int unsigned      PC_W      = 25,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    localparam int unsigned     BEAT_HW   = FETCH_W / HW_W,
    localparam int unsigned     WC_W      = $clog2(WINDOW_HW + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_valid_i,
    input  logic [PC_W-1:0]             redirect_pc_i,
    output logic                        mem_req_o,
    output logic [PC_W-1:0]             mem_addr_o,
    input  logic                        mem_gnt_i,
    input  logic                        mem_rvalid_i,
    input  logic [FETCH_W-1:0]          mem_rdata_i,
    output logic [WINDOW_HW*HW_W-1:0]   window_o,
    output logic [WC_W-1:0]             win_count_o,
    output logic [PC_W-1:0]             pc_o,
    input  logic [WC_W-1:0]             consume_i
);

    localparam int unsigned CNT_W  = $clog2(DEPTH_HW + 1);
    localparam int unsigned CA_W   = CNT_W + 1;
    localparam int unsigned SKIP_W = (BEAT_HW > 1) ? $clog2(BEAT_HW) : 1;

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic               r_mem_req;
    logic [PC_W-1:0]    r_fetch_addr;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_aligned;
    logic [SKIP_W-1:0]  w_skip;
    logic [CNT_W-1:0]   w_count;
    logic [CA_W-1:0]    w_wr_num;
    logic [CA_W-1:0]    w_count_after;
    logic               w_enq;
    logic               w_space_ok;
    logic               w_space_after_ok;

    assign w_aligned = r_fetch_addr & ~PC_W'(BEAT_HW - 1);
    assign w_skip    = SKIP_W'(r_fetch_addr & PC_W'(BEAT_HW - 1));
    assign w_enq     = (r_state == WAIT) && mem_rvalid_i && !redirect_valid_i;

    // Occupancy after this cycle's enqueue and consume decides whether to refetch.
    assign w_wr_num         = w_enq ? (CA_W'(BEAT_HW) - CA_W'(w_skip)) : '0;
    assign w_count_after    = CA_W'(w_count) + w_wr_num - CA_W'(consume_i);
    assign w_space_ok       = w_count <= CNT_W'(DEPTH_HW - BEAT_HW);
    assign w_space_after_ok = w_count_after <= CA_W'(DEPTH_HW - BEAT_HW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_mem_req <= (w_next_state == REQ);
        end
    end

    // A redirect while a response is owed must swallow that response first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (redirect_valid_i || w_space_ok) w_next_state = REQ;
            end
            REQ: begin
                if (mem_gnt_i) w_next_state = redirect_valid_i ? DRAIN : WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    w_next_state = (redirect_valid_i || w_space_after_ok) ? REQ : IDLE;
                end else if (redirect_valid_i) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) w_next_state = REQ;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_addr <= RESET_PC;
            r_pc         <= RESET_PC;
        end else if (redirect_valid_i) begin
            r_fetch_addr <= redirect_pc_i;
            r_pc         <= redirect_pc_i;
        end else begin
            if (w_enq) r_fetch_addr <= w_aligned + PC_W'(BEAT_HW);
            r_pc <= r_pc + PC_W'(consume_i);
        end
    end

    v850_hw_ring #(
        .DEPTH_HW  (DEPTH_HW),
        .BEAT_HW   (BEAT_HW),
        .WINDOW_HW (WINDOW_HW)
    ) u_ring (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid_i),
        .i_wr_en     (w_enq),
        .i_wr_skip   (w_skip),
        .i_wr_data   (mem_rdata_i),
        .i_rd_cnt    (consume_i),
        .o_count     (w_count),
        .o_window    (window_o),
        .o_win_count (win_count_o)
    );

    assign mem_req_o  = r_mem_req;
    assign mem_addr_o = w_aligned;
    assign pc_o       = r_pc;

endmodule

// File: tb/tb_v850_prefetch_queue.sv
// Directed bench for v850_prefetch_queue with an address-pattern memory of programmable latency.
module tb_v850_prefetch_queue;

    localparam int unsigned PC_W = 25;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               redirect_valid_i = 1'b0;
    logic [PC_W-1:0]    redirect_pc_i = '0;
    logic               mem_req_o;
    logic [PC_W-1:0]    mem_addr_o;
    logic               mem_gnt_i = 1'b0;
    logic               mem_rvalid_i = 1'b0;
    logic [31:0]        mem_rdata_i = '0;
    logic [63:0]        window_o;
    logic [2:0]         win_count_o;
    logic [PC_W-1:0]    pc_o;
    logic [2:0]         consume_i = '0;

    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 lat = 1;
    int                 cd = -1;
    logic [PC_W-1:0]    paddr = '0;
    logic [PC_W-1:0]    pcm;
    int unsigned        c;

    v850_prefetch_queue dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .window_o         (window_o),
        .win_count_o      (win_count_o),
        .pc_o             (pc_o),
        .consume_i        (consume_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory: grant always, return halfword i of a beat as (beat address + i) after 'lat' cycles.
    task automatic mem_model();
        mem_rvalid_i = 1'b0;
        if (cd == 1) begin
            mem_rvalid_i = 1'b1;
            for (int i = 0; i < 2; i++) mem_rdata_i[16*i +: 16] = 16'(paddr + PC_W'(i));
            cd = -1;
        end else if (cd > 1) begin
            cd--;
        end
        mem_gnt_i = 1'b1;
        if (mem_req_o && mem_gnt_i) begin
            cd    = lat;
            paddr = mem_addr_o;
        end
    endtask

    task automatic tick();
        check("consume_le_win", 64'(consume_i <= win_count_o), 64'(1));
        @(posedge clk);
        @(negedge clk);
        mem_model();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_win(input string tag);
        int k = 0;
        while (win_count_o == 0 && k < 20) begin
            tick();
            k++;
        end
        check(tag, 64'(win_count_o != 0), 64'(1));
    endtask

    function automatic logic [63:0] win_exp(input logic [PC_W-1:0] base, input int n);
        logic [63:0] w = '0;
        for (int i = 0; i < 4; i++)
            if (i < n) w[16*i +: 16] = 16'(base + PC_W'(i));
        return w;
    endfunction

    task automatic redirect(input logic [PC_W-1:0] tgt);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = tgt;
        tick();
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_req", 64'(mem_req_o), 64'(0));
        check("rst_pc", 64'(pc_o), 64'(0));
        check("rst_wcnt", 64'(win_count_o), 64'(0));
        check("rst_win", window_o, 64'(0));
        rst_n = 1'b1;
        mem_model();

        // Prime from reset address
        tick();
        check("first_req", 64'(mem_req_o), 64'(1));
        check("first_addr", 64'(mem_addr_o), 64'(0));
        idle_ticks(4);
        check("prime_wcnt", 64'(win_count_o), 64'(4));
        check("prime_win", window_o, 64'h0003_0002_0001_0000);
        check("prime_pc", 64'(pc_o), 64'(0));

        // No consume: queue fills and fetching stops
        idle_ticks(20);
        check("full_req", 64'(mem_req_o), 64'(0));
        check("full_wcnt", 64'(win_count_o), 64'(4));
        check("full_win", window_o, 64'h0003_0002_0001_0000);
        consume_i = 3'd4;
        tick();
        consume_i = 3'd0;
        check("c4_pc", 64'(pc_o), 64'(4));
        check("c4_win", window_o, 64'h0007_0006_0005_0004);
        check("c4_wcnt", 64'(win_count_o), 64'(4));
        tick();
        check("resume_req", 64'(mem_req_o), 64'(1));
        check("resume_addr", 64'(mem_addr_o), 64'(8));

        // Sustained stream consuming up to 2 halfwords per cycle
        pcm = 25'd4;
        for (int i = 0; i < 30; i++) begin
            c = (win_count_o >= 3'd2) ? 2 : 32'(win_count_o);
            consume_i = 3'(c);
            tick();
            pcm = pcm + PC_W'(c);
            check("strm_pc", 64'(pc_o), 64'(pcm));
            check("strm_win", window_o, win_exp(pcm, int'(win_count_o)));
        end
        consume_i = 3'd0;
        check("strm_advanced", 64'(pc_o > 25'd20), 64'(1));
        idle_ticks(20);

        // Unaligned redirect: first beat supplies only the target halfword
        redirect(25'h13);
        check("ua_pc", 64'(pc_o), 64'h13);
        check("ua_wcnt0", 64'(win_count_o), 64'(0));
        check("ua_win0", window_o, 64'(0));
        check("ua_req", 64'(mem_req_o), 64'(1));
        check("ua_addr", 64'(mem_addr_o), 64'h12);
        idle_ticks(2);
        check("ua_wcnt1", 64'(win_count_o), 64'(1));
        check("ua_win1", window_o, 64'h0000_0000_0000_0013);
        idle_ticks(2);
        check("ua_wcnt3", 64'(win_count_o), 64'(3));
        check("ua_win3", window_o, 64'h0000_0015_0014_0013);
        check("ua_pc2", 64'(pc_o), 64'h13);
        idle_ticks(20);

        // Redirect during WAIT with a slow response: old beat is dropped
        lat = 3;
        redirect(25'h40);
        check("w_req", 64'(mem_req_o), 64'(1));
        check("w_addr", 64'(mem_addr_o), 64'h40);
        tick();
        redirect(25'h80);
        check("w_pc", 64'(pc_o), 64'h80);
        check("w_wcnt0", 64'(win_count_o), 64'(0));
        check("w_drain_req", 64'(mem_req_o), 64'(0));
        tick();
        check("w_drain_req2", 64'(mem_req_o), 64'(0));
        tick();
        check("w_req2", 64'(mem_req_o), 64'(1));
        check("w_addr2", 64'(mem_addr_o), 64'h80);
        check("w_wcnt_post", 64'(win_count_o), 64'(0));
        wait_win("w_wait_data");
        check("w_win", window_o, 64'h0000_0000_0081_0080);
        check("w_wcnt2", 64'(win_count_o), 64'(2));
        check("w_pc2", 64'(pc_o), 64'h80);

        // Redirect coinciding with rvalid and a consume of 2
        lat = 1;
        begin
            int k = 0;
            while (!(mem_rvalid_i && win_count_o >= 3'd2) && k < 20) begin
                tick();
                k++;
            end
            check("rv_wait", 64'(mem_rvalid_i && win_count_o >= 3'd2), 64'(1));
        end
        consume_i = 3'd2;
        redirect(25'h100);
        consume_i = 3'd0;
        check("rv_pc", 64'(pc_o), 64'h100);
        check("rv_wcnt", 64'(win_count_o), 64'(0));
        check("rv_win", window_o, 64'(0));
        check("rv_req", 64'(mem_req_o), 64'(1));
        check("rv_addr", 64'(mem_addr_o), 64'h100);
        wait_win("rv_wait_data");
        check("rv_win2", window_o, 64'h0000_0000_0101_0100);
        check("rv_pc2", 64'(pc_o), 64'h100);

        // Asynchronous reset in the middle of WAIT
        lat = 3;
        redirect(25'h200);
        tick();
        rst_n = 1'b0;
        #1;
        check("ar_req", 64'(mem_req_o), 64'(0));
        check("ar_addr", 64'(mem_addr_o), 64'(0));
        check("ar_pc", 64'(pc_o), 64'(0));
        check("ar_wcnt", 64'(win_count_o), 64'(0));
        check("ar_win", window_o, 64'(0));
        cd = -1;
        mem_rvalid_i = 1'b0;
        lat = 1;
        @(negedge clk);
        rst_n = 1'b1;
        idle_ticks(5);
        check("ar_prime_win", window_o, 64'h0003_0002_0001_0000);
        check("ar_prime_wcnt", 64'(win_count_o), 64'(4));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
